// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared types and helpers for the keypad entry block.
//   state_t            : key-handling FSM states
//   BLANK_CODE_DEFAULT : digit code that lights no segments
//   onehot_index()     : {valid, index} of a one-hot key vector
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    DEB_REL,
    WAIT_REL
  } state_t;

  localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hA;

  // onehot_index works on a fixed-width vector; narrower key vectors are
  // zero-extended by the caller.
  localparam int MAX_KEYS = 64;
  localparam int INDEX_W  = 6;

  typedef struct packed {
    logic               valid;
    logic [INDEX_W-1:0] index;
  } onehot_t;

  // valid is set only when exactly one bit is high; index is then the
  // position of that bit.
  function automatic onehot_t onehot_index(input logic [MAX_KEYS-1:0] vec);
    onehot_t r;
    int      ones;
    r.valid = 1'b0;
    r.index = '0;
    ones    = 0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (vec[i]) begin
        ones++;
        r.index = INDEX_W'(i);
      end
    end
    r.valid = (ones == 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if -- button inputs and entry outputs of keypad_entry.
//   master : the keypad_entry side (reads buttons/clear, drives entry state)
//   slave  : the board / consumer side
// Signals:
//   keypad_buttons [NUM_KEYS]        raw active-high buttons
//   clear                            request to blank the entry
//   keypad_values  [DIGITS*DIGIT_W]  entry register, newest digit in LSBs
//   shift_pulse                      one-cycle strobe per committed digit
//   digit_count    [clog2(DIGITS+1)] digits entered, saturating
//   entry_full                       digit_count == DIGITS
//   multi_key_err                    one-cycle strobe on a non one-hot press
interface keypad_if #(
  parameter int NUM_KEYS = 10,
  parameter int DIGITS   = 4,
  parameter int DIGIT_W  = 4
);
  localparam int COUNT_W = $clog2(DIGITS + 1);

  logic [NUM_KEYS-1:0]       keypad_buttons;
  logic                      clear;
  logic [DIGITS*DIGIT_W-1:0] keypad_values;
  logic                      shift_pulse;
  logic [COUNT_W-1:0]        digit_count;
  logic                      entry_full;
  logic                      multi_key_err;

  modport master (
    input  keypad_buttons, clear,
    output keypad_values, shift_pulse, digit_count, entry_full, multi_key_err
  );

  modport slave (
    output keypad_buttons, clear,
    input  keypad_values, shift_pulse, digit_count, entry_full, multi_key_err
  );
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce -- two-flop synchroniser on every button bit plus a
// stability counter over the whole synchronised vector.
// Ports:
//   clk, reset_n    clock, asynchronous active-low reset
//   raw   [WIDTH]   asynchronous button inputs
//   sync  [WIDTH]   synchronised vector
//   stable_expired  high once sync has been unchanged for DEBOUNCE_CYCLES
//                   cycles; stays high until sync changes again
module keypad_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sync,
  output logic             stable_expired
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] meta_vec;
  logic [CNT_W-1:0] cnt_reg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= raw[gi];
        sync_reg <= meta_reg;
      end
    end
    assign meta_vec[gi] = meta_reg;
    assign sync[gi]     = sync_reg;
  end

  // The counter restarts on the same edge that sync takes a new value, so
  // every FSM transition that is caused by a change of sync sees a freshly
  // loaded counter without needing an explicit load strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (meta_vec != sync) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stable_expired = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry -- debounced keypad decoder feeding a DIGITS-deep entry
// shift register. A single one-hot key press is committed on release;
// multi-key presses are rejected with multi_key_err.
// Build option: define KEYPAD_AUTOREPEAT_EN to commit the held key every
// REPEAT_CYCLES cycles while it is held (no extra commit on release once a
// repeat has fired).
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       keypad_if.master (buttons/clear in, entry state out)
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int               NUM_KEYS        = 10,
  parameter int               DIGITS          = 4,
  parameter int               DIGIT_W         = 4,
  parameter logic [DIGIT_W-1:0] BLANK_CODE    = DIGIT_W'(BLANK_CODE_DEFAULT),
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               REPEAT_CYCLES   = 50000
) (
  input logic      clk,
  input logic      reset_n,
  keypad_if.master bus
);

  localparam int                     COUNT_W    = $clog2(DIGITS + 1);
  localparam logic [COUNT_W-1:0]     COUNT_MAX  = COUNT_W'(DIGITS);
  localparam logic [DIGITS*DIGIT_W-1:0] BLANK_FILL = {DIGITS{BLANK_CODE}};

  // Parameter sanity checks at elaboration.
  if (NUM_KEYS > 2 ** DIGIT_W) begin : g_bad_keys
    $error("keypad_entry: NUM_KEYS does not fit in DIGIT_W bits");
  end
  if (int'(BLANK_CODE) < NUM_KEYS) begin : g_bad_blank
    $error("keypad_entry: BLANK_CODE collides with a key code");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("keypad_entry: DIGITS must be at least 1");
  end
  if (NUM_KEYS > MAX_KEYS) begin : g_bad_width
    $error("keypad_entry: NUM_KEYS exceeds onehot_index width");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("keypad_entry: DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("keypad_entry: REPEAT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------- input
  logic [NUM_KEYS-1:0] sync_keys;
  logic                stable_expired;

  keypad_debounce #(
    .WIDTH           (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk            (clk),
    .reset_n        (reset_n),
    .raw            (bus.keypad_buttons),
    .sync           (sync_keys),
    .stable_expired (stable_expired)
  );

  // ------------------------------------------------------------------ FSM
  state_t              state_reg;
  logic [NUM_KEYS-1:0] capture_reg;
  logic [DIGIT_W-1:0]  code_reg;
  logic                multi_key_err_reg;

  logic                keys_idle;
  logic                keys_match;
  logic [MAX_KEYS-1:0] capture_wide;
  onehot_t             capture_oh;

  assign keys_idle    = (sync_keys == '0);
  assign keys_match   = (sync_keys == capture_reg);
  assign capture_wide = MAX_KEYS'(capture_reg);
  assign capture_oh   = onehot_index(capture_wide);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= IDLE;
      capture_reg       <= '0;
      code_reg          <= '0;
      multi_key_err_reg <= 1'b0;
    end else begin
      multi_key_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!keys_idle) begin
            state_reg   <= DEB_PRESS;
            capture_reg <= sync_keys;
          end
        end
        DEB_PRESS: begin
          if (keys_idle) begin
            state_reg <= IDLE;
          end else if (!keys_match) begin
            capture_reg <= sync_keys;
          end else if (stable_expired) begin
            if (capture_oh.valid) begin
              code_reg  <= DIGIT_W'(capture_oh.index);
              state_reg <= HELD;
            end else begin
              multi_key_err_reg <= 1'b1;
              state_reg         <= WAIT_REL;
            end
          end
        end
        HELD: begin
          // Changes between non-zero vectors are ignored; the latched code
          // stands until every key is released.
          if (keys_idle) begin
            state_reg <= DEB_REL;
          end
        end
        DEB_REL: begin
          if (!keys_idle) begin
            state_reg <= HELD;
          end else if (stable_expired) begin
            state_reg <= IDLE;
          end
        end
        WAIT_REL: begin
          if (keys_idle && stable_expired) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- autorepeat
  logic repeat_fire;
  logic repeated;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt_reg;
  logic             repeated_reg;

  assign repeat_fire = (state_reg == HELD) && (rpt_cnt_reg == RPT_LAST);
  assign repeated    = repeated_reg;

  // Every hold is entered through DEB_PRESS, which re-arms the counter.
  // The counter pauses (but is not cleared) while a release is being
  // debounced, so a bounce back into HELD keeps its phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_reg  <= '0;
      repeated_reg <= 1'b0;
    end else if (state_reg == DEB_PRESS) begin
      rpt_cnt_reg  <= '0;
      repeated_reg <= 1'b0;
    end else if (state_reg == HELD) begin
      if (repeat_fire) begin
        rpt_cnt_reg  <= '0;
        repeated_reg <= 1'b1;
      end else begin
        rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign repeat_fire = 1'b0;
  assign repeated    = 1'b0;
`endif

  // ------------------------------------------------------- entry register
  logic                      release_commit;
  logic                      commit_req;
  logic [DIGITS*DIGIT_W-1:0] values_reg;
  logic [DIGITS*DIGIT_W-1:0] shifted;
  logic [COUNT_W-1:0]        count_reg;
  logic                      shift_pulse_reg;

  assign release_commit = (state_reg == DEB_REL) && keys_idle &&
                          stable_expired && !repeated;
  assign commit_req     = release_commit || repeat_fire;

  if (DIGITS == 1) begin : g_shift_one
    assign shifted = code_reg;
  end else begin : g_shift_many
    assign shifted = {values_reg[(DIGITS-1)*DIGIT_W-1:0], code_reg};
  end

  // clear has priority: a digit committing on the same edge is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      values_reg      <= BLANK_FILL;
      count_reg       <= '0;
      shift_pulse_reg <= 1'b0;
    end else begin
      shift_pulse_reg <= 1'b0;
      if (bus.clear) begin
        values_reg <= BLANK_FILL;
        count_reg  <= '0;
      end else if (commit_req) begin
        values_reg      <= shifted;
        shift_pulse_reg <= 1'b1;
        if (count_reg != COUNT_MAX) begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  assign bus.keypad_values = values_reg;
  assign bus.shift_pulse   = shift_pulse_reg;
  assign bus.digit_count   = count_reg;
  assign bus.entry_full    = (count_reg == COUNT_MAX);
  assign bus.multi_key_err = multi_key_err_reg;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry -- directed self-checking bench for keypad_entry with
// DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20, NUM_KEYS=10, DIGITS=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_keypad_entry;

  localparam int NUM_KEYS = 10;
  localparam int DIGITS   = 4;
  localparam int DIGIT_W  = 4;
  localparam int DEB      = 4;
  localparam int RPT      = 20;
  localparam int LAT      = DEB + 3;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  keypad_if #(.NUM_KEYS(NUM_KEYS), .DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus ();

  keypad_entry #(
    .NUM_KEYS        (NUM_KEYS),
    .DIGITS          (DIGITS),
    .DIGIT_W         (DIGIT_W),
    .BLANK_CODE      (4'hA),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int n_vec     = 0;
  int n_err     = 0;
  int pulse_cnt = 0;
  int err_cnt   = 0;

  // Strobe counters, sampled on the rising edge so they never race with the
  // falling-edge checks below.
  always @(posedge clk) begin
    if (bus.shift_pulse)   pulse_cnt++;
    if (bus.multi_key_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic hold_keys(input logic [NUM_KEYS-1:0] v, input int cycles);
    bus.keypad_buttons = v;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic logic [NUM_KEYS-1:0] key(input int k);
    logic [NUM_KEYS-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Release all keys and check that exactly one shift_pulse appears LAT
  // cycles later with the expected register contents.
  task automatic release_and_expect(input string tag, input logic [15:0] exp_values,
                                    input int exp_count);
    bus.keypad_buttons = '0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      check({tag, "_pulse"}, 32'(bus.shift_pulse), 32'(i == LAT));
    end
    check({tag, "_values"}, 32'(bus.keypad_values), 32'(exp_values));
    check({tag, "_count"}, 32'(bus.digit_count), 32'(exp_count));
    check({tag, "_full"}, 32'(bus.entry_full), 32'(exp_count == DIGITS));
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.shift_pulse), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    int          e0;
    logic [15:0] model_values;
    int          model_count;

    bus.keypad_buttons = '0;
    bus.clear          = 1'b0;
    reset_n            = 1'b0;

    // ---- reset state
    repeat (3) @(negedge clk);
    check("rst_values", 32'(bus.keypad_values), 32'h0000_AAAA);
    check("rst_count", 32'(bus.digit_count), 32'd0);
    check("rst_full", 32'(bus.entry_full), 32'd0);
    check("rst_pulse", 32'(bus.shift_pulse), 32'd0);
    check("rst_err", 32'(bus.multi_key_err), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- key 7, clean press
    p0 = pulse_cnt;
    hold_keys(key(7), 10);
    release_and_expect("k7", 16'hAAA7, 1);
    check("k7_npulse", 32'(pulse_cnt - p0), 32'd1);

    // ---- key 3 with bounce on press and on release
    p0 = pulse_cnt;
    hold_keys(key(3), 2);
    hold_keys('0, 2);
    hold_keys(key(3), 10);
    hold_keys('0, 2);
    hold_keys(key(3), 2);
    release_and_expect("k3_bounce", 16'hAA73, 2);
    check("k3_npulse", 32'(pulse_cnt - p0), 32'd1);

    // ---- keys 1..5 fill and overflow the entry
    model_values = 16'hAA73;
    model_count  = 2;
    for (int k = 1; k <= 5; k++) begin
      model_values = {model_values[11:0], 4'(k)};
      if (model_count < DIGITS) model_count++;
      hold_keys(key(k), 8);
      release_and_expect($sformatf("seq_k%0d", k), model_values, model_count);
      repeat (3) @(negedge clk);
    end
    check("seq_final", 32'(bus.keypad_values), 32'h0000_2345);

    // ---- keys 2 and 5 together
    p0 = pulse_cnt;
    e0 = err_cnt;
    bus.keypad_buttons = key(2) | key(5);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("multi_err", 32'(bus.multi_key_err), 32'(i == LAT));
    end
    hold_keys(key(2) | key(5), 4);
    hold_keys('0, 12);
    check("multi_nerr", 32'(err_cnt - e0), 32'd1);
    check("multi_npulse", 32'(pulse_cnt - p0), 32'd0);
    check("multi_values", 32'(bus.keypad_values), 32'h0000_2345);
    check("multi_count", 32'(bus.digit_count), 32'd4);

    // ---- clear on the commit edge of key 9
    p0 = pulse_cnt;
    hold_keys(key(9), 8);
    bus.keypad_buttons = '0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i < LAT) check("clr_pre_pulse", 32'(bus.shift_pulse), 32'd0);
      if (i == LAT - 1) bus.clear = 1'b1;
    end
    bus.clear = 1'b0;
    check("clr_pulse", 32'(bus.shift_pulse), 32'd0);
    check("clr_values", 32'(bus.keypad_values), 32'h0000_AAAA);
    check("clr_count", 32'(bus.digit_count), 32'd0);
    check("clr_full", 32'(bus.entry_full), 32'd0);
    repeat (6) @(negedge clk);
    check("clr_npulse", 32'(pulse_cnt - p0), 32'd0);

    // ---- clear during a hold does not disturb the press
    hold_keys(key(8), 5);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    hold_keys(key(8), 4);
    release_and_expect("clr_hold_k8", 16'hAAA8, 1);

    // ---- reset while key 4 is in release debounce
    p0 = pulse_cnt;
    hold_keys(key(4), 8);
    hold_keys('0, 4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_values", 32'(bus.keypad_values), 32'h0000_AAAA);
    check("mid_rst_count", 32'(bus.digit_count), 32'd0);
    check("mid_rst_pulse", 32'(bus.shift_pulse), 32'd0);
    check("mid_rst_full", 32'(bus.entry_full), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_rst_npulse", 32'(pulse_cnt - p0), 32'd0);
    check("mid_rst_after", 32'(bus.keypad_values), 32'h0000_AAAA);

    // ---- key 6 held for 70 cycles
    p0 = pulse_cnt;
    hold_keys(key(6), 70);
    hold_keys('0, 15);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold6_npulse", 32'(pulse_cnt - p0), 32'd3);
    check("hold6_values", 32'(bus.keypad_values), 32'h0000_A666);
    check("hold6_count", 32'(bus.digit_count), 32'd3);
`else
    check("hold6_npulse", 32'(pulse_cnt - p0), 32'd1);
    check("hold6_values", 32'(bus.keypad_values), 32'h0000_AAA6);
    check("hold6_count", 32'(bus.digit_count), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
